clk_display_mux: RTL and testbench

CLK_DISPLAY_MUX -- requirements
Module: clk_display_mux

---
 rtl/clk_display_mux.sv | 119 +++++++++++
 tb/tb_clk_display_mux.sv | 111 +++++++++++
 2 files changed

// File: rtl/clk_display_mux.sv
// clk_display_mux: converts binary minutes/seconds to BCD by double-dabble and
// scans them onto a 4-digit active-low seven-segment display.
module clk_display_mux #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] seconds_in,
   input  logic [5:0] minutes_in,
   output logic [6:0] seg_out,
   output logic [3:0] an_out,
   output logic       dp_out,
   output logic       conv_busy
);
   localparam int CW = $clog2(REFRESH_DIV);
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
   state_t state_q, state_d;
   logic [5:0] sec_q, min_q;
   logic [11:0] last_conv_q, last_conv_d;
   logic [13:0] ss_q, ss_d, ms_q, ms_d;
   logic [2:0] it_q, it_d;
   logic [3:0][3:0] dig_q, dig_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] seg_d;
   logic [3:0] an_d;
   logic dp_d;
   logic wrap;
   // shift word is {tens, ones, binary}; one adjust-then-shift iteration
   function automatic logic [13:0] dabble(input logic [13:0] v);
      logic [3:0] t, o;
      t = v[13:10] >= 4'd5 ? v[13:10] + 4'd3 : v[13:10];
      o = v[9:6] >= 4'd5 ? v[9:6] + 4'd3 : v[9:6];
      return {t, o, v[5:0]} << 1;
   endfunction
   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sec_q       <= '0;
         min_q       <= '0;
         last_conv_q <= '0;
         ss_q        <= '0;
         ms_q        <= '0;
         it_q        <= '0;
         dig_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         seg_out     <= 7'b1111111;
         an_out      <= 4'b1111;
         dp_out      <= 1'b1;
      end else begin
         state_q     <= state_d;
         sec_q       <= seconds_in;
         min_q       <= minutes_in;
         last_conv_q <= last_conv_d;
         ss_q        <= ss_d;
         ms_q        <= ms_d;
         it_q        <= it_d;
         dig_q       <= dig_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         seg_out     <= seg_d;
         an_out      <= an_d;
         dp_out      <= dp_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      last_conv_d = last_conv_q;
      ss_d        = ss_q;
      ms_d        = ms_q;
      it_d        = it_q;
      dig_d       = dig_q;
      case (state_q)
         IDLE: if ({min_q, sec_q} != last_conv_q) begin
            last_conv_d = {min_q, sec_q};
            ss_d        = {8'd0, sec_q};
            ms_d        = {8'd0, min_q};
            it_d        = '0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            ss_d    = dabble(ss_q);
            ms_d    = dabble(ms_q);
            it_d    = it_q + 3'd1;
            state_d = it_q == 3'd5 ? LOAD : SHIFT;
         end
         LOAD: begin
            dig_d   = {ms_q[13:10], ms_q[9:6], ss_q[13:10], ss_q[9:6]};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      conv_busy = state_q != IDLE;
      wrap      = cnt_q == CW'(REFRESH_DIV - 1);
      cnt_d     = wrap ? '0 : cnt_q + CW'(1);
      idx_d     = wrap ? idx_q + 2'd1 : idx_q;
      seg_d     = enc(dig_q[idx_q]);
      an_d      = ~(4'b0001 << idx_q);
      dp_d      = idx_q != 2'd2;
   end
endmodule

// File: tb/tb_clk_display_mux.sv
// tb_clk_display_mux: random and directed stimulus checked every cycle against a
// countdown/arithmetic reference model of the converter and scanner.
module tb_clk_display_mux;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [5:0] seconds_in = '0;
   logic [5:0] minutes_in = '0;
   logic [6:0] seg_out;
   logic [3:0] an_out;
   logic dp_out, conv_busy;
   int total = 0, bad = 0;
   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int m_reg, m_last, m_rem, m_cnt, m_idx;
   int m_dig [4];
   logic [6:0] e_seg;
   logic [3:0] e_an;
   logic e_dp, e_busy;
   int busy_cnt;
   clk_display_mux #(.REFRESH_DIV(4)) dut (
      .clk(clk), .reset(reset), .seconds_in(seconds_in), .minutes_in(minutes_in),
      .seg_out(seg_out), .an_out(an_out), .dp_out(dp_out), .conv_busy(conv_busy)
   );
   always #5 clk = ~clk;
   function automatic logic [6:0] enc(input int d);
      return d < 10 ? SEG[d] : 7'h7f;
   endfunction
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_reg = 0; m_last = 0; m_rem = 0; m_cnt = 0; m_idx = 0;
         m_dig = '{0, 0, 0, 0};
         e_seg = 7'h7f; e_an = 4'hf; e_dp = 1'b1;
      end else begin
         e_seg = enc(m_dig[m_idx]);
         e_an = ~(4'b0001 << m_idx);
         e_dp = m_idx != 2;
         if (m_rem == 0) begin
            if (m_reg != m_last) begin
               m_last = m_reg;
               m_rem = 7;
            end
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_dig[0] = (m_last % 64) % 10;
               m_dig[1] = (m_last % 64) / 10;
               m_dig[2] = (m_last / 64) % 10;
               m_dig[3] = (m_last / 64) / 10;
            end
         end
         if (m_cnt == 3) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
         end else m_cnt++;
         m_reg = minutes_in * 64 + seconds_in;
      end
      e_busy = m_rem != 0;
      #1;
      busy_cnt += int'(conv_busy);
      total++;
      assert (seg_out === e_seg) else begin bad++; $error("FAIL seg: got %b want %b", seg_out, e_seg); end
      total++;
      assert (an_out === e_an) else begin bad++; $error("FAIL an: got %b want %b", an_out, e_an); end
      total++;
      assert (dp_out === e_dp) else begin bad++; $error("FAIL dp: got %b want %b", dp_out, e_dp); end
      total++;
      assert (conv_busy === e_busy) else begin bad++; $error("FAIL busy: got %b want %b", conv_busy, e_busy); end
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      busy_cnt = 0;
      run(3);
      reset = 1'b0;
      run(40);
      busy_cnt = 0;
      minutes_in = 6'd12; seconds_in = 6'd34;
      run(40);
      total++;
      assert (busy_cnt === 7) else begin bad++; $error("FAIL busy_len: got %0d want 7", busy_cnt); end
      seconds_in = 6'd59;
      run(5);
      seconds_in = 6'd0;
      run(40);
      minutes_in = 6'd63; seconds_in = 6'd60;
      run(30);
      minutes_in = 6'd45; seconds_in = 6'd17;
      run(4);
      reset = 1'b1; minutes_in = '0; seconds_in = '0;
      run(1);
      reset = 1'b0;
      run(30);
      for (int v = 0; v < 60; v++) begin
         seconds_in = 6'(v);
         run(20);
      end
      for (int i = 0; i < 200; i++) begin
         minutes_in = 6'($urandom_range(0, 63));
         seconds_in = 6'($urandom_range(0, 63));
         reset = $urandom_range(0, 19) == 0;
         run(1);
         reset = 1'b0;
         run($urandom_range(1, 15));
      end
      run(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
